// File: rtl/rvm_instr_decode_pkg.sv
// Shared constants for the fetch-capture/decode stage: major opcodes, instruction
// identifier codes, immediate formats, FSM states and the immediate builder.
package rvm_instr_decode_pkg;

    localparam logic [6:0] RVM_OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] RVM_OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] RVM_OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] RVM_OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] RVM_OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] RVM_OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] RVM_OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] RVM_OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] RVM_OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] RVM_OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] RVM_OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [5:0] RVM_INSTR_INVALID = 6'd0;
    localparam logic [5:0] RVM_INSTR_LUI     = 6'd1;
    localparam logic [5:0] RVM_INSTR_AUIPC   = 6'd2;
    localparam logic [5:0] RVM_INSTR_JAL     = 6'd3;
    localparam logic [5:0] RVM_INSTR_JALR    = 6'd4;
    localparam logic [5:0] RVM_INSTR_BEQ     = 6'd5;
    localparam logic [5:0] RVM_INSTR_BNE     = 6'd6;
    localparam logic [5:0] RVM_INSTR_BLT     = 6'd7;
    localparam logic [5:0] RVM_INSTR_BGE     = 6'd8;
    localparam logic [5:0] RVM_INSTR_BLTU    = 6'd9;
    localparam logic [5:0] RVM_INSTR_BGEU    = 6'd10;
    localparam logic [5:0] RVM_INSTR_LB      = 6'd11;
    localparam logic [5:0] RVM_INSTR_LH      = 6'd12;
    localparam logic [5:0] RVM_INSTR_LW      = 6'd13;
    localparam logic [5:0] RVM_INSTR_LBU     = 6'd14;
    localparam logic [5:0] RVM_INSTR_LHU     = 6'd15;
    localparam logic [5:0] RVM_INSTR_SB      = 6'd16;
    localparam logic [5:0] RVM_INSTR_SH      = 6'd17;
    localparam logic [5:0] RVM_INSTR_SW      = 6'd18;
    localparam logic [5:0] RVM_INSTR_ADDI    = 6'd19;
    localparam logic [5:0] RVM_INSTR_SLTI    = 6'd20;
    localparam logic [5:0] RVM_INSTR_SLTIU   = 6'd21;
    localparam logic [5:0] RVM_INSTR_XORI    = 6'd22;
    localparam logic [5:0] RVM_INSTR_ORI     = 6'd23;
    localparam logic [5:0] RVM_INSTR_ANDI    = 6'd24;
    localparam logic [5:0] RVM_INSTR_SLLI    = 6'd25;
    localparam logic [5:0] RVM_INSTR_SRLI    = 6'd26;
    localparam logic [5:0] RVM_INSTR_SRAI    = 6'd27;
    localparam logic [5:0] RVM_INSTR_ADD     = 6'd28;
    localparam logic [5:0] RVM_INSTR_SUB     = 6'd29;
    localparam logic [5:0] RVM_INSTR_SLL     = 6'd30;
    localparam logic [5:0] RVM_INSTR_SLT     = 6'd31;
    localparam logic [5:0] RVM_INSTR_SLTU    = 6'd32;
    localparam logic [5:0] RVM_INSTR_XOR     = 6'd33;
    localparam logic [5:0] RVM_INSTR_SRL     = 6'd34;
    localparam logic [5:0] RVM_INSTR_SRA     = 6'd35;
    localparam logic [5:0] RVM_INSTR_OR      = 6'd36;
    localparam logic [5:0] RVM_INSTR_AND     = 6'd37;
    localparam logic [5:0] RVM_INSTR_FENCE   = 6'd38;
    localparam logic [5:0] RVM_INSTR_ECALL   = 6'd39;
    localparam logic [5:0] RVM_INSTR_EBREAK  = 6'd40;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ,
        ImmShamt
    } imm_fmt_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDecode,
        StHold
    } state_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] word, input imm_fmt_e fmt);
        logic [31:0] res;
        res = '0;
        case (fmt)
            ImmI:     res = {{20{word[31]}}, word[31:20]};
            ImmS:     res = {{20{word[31]}}, word[31:25], word[11:7]};
            ImmB:     res = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
            ImmU:     res = {word[31:12], 12'b0};
            ImmJ:     res = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
            ImmShamt: res = {27'b0, word[24:20]};
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rvm_decode_comb.sv
// Purely combinational instruction word decoder: identifier code and immediate.
// Any word without an exact opcode/funct match decodes to code 0 with a zero immediate.
module rvm_decode_comb
    import rvm_instr_decode_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  instr,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_fmt_e   fmt;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        instr = RVM_INSTR_INVALID;
        fmt   = ImmNone;
        case (opcode)
            RVM_OPCODE_LUI: begin
                instr = RVM_INSTR_LUI;
                fmt   = ImmU;
            end
            RVM_OPCODE_AUIPC: begin
                instr = RVM_INSTR_AUIPC;
                fmt   = ImmU;
            end
            RVM_OPCODE_JAL: begin
                instr = RVM_INSTR_JAL;
                fmt   = ImmJ;
            end
            RVM_OPCODE_JALR: begin
                fmt = ImmI;
                if (funct3 == 3'b000) instr = RVM_INSTR_JALR;
            end
            RVM_OPCODE_BRANCH: begin
                fmt = ImmB;
                case (funct3)
                    3'b000:  instr = RVM_INSTR_BEQ;
                    3'b001:  instr = RVM_INSTR_BNE;
                    3'b100:  instr = RVM_INSTR_BLT;
                    3'b101:  instr = RVM_INSTR_BGE;
                    3'b110:  instr = RVM_INSTR_BLTU;
                    3'b111:  instr = RVM_INSTR_BGEU;
                    default: instr = RVM_INSTR_INVALID;
                endcase
            end
            RVM_OPCODE_LOAD: begin
                fmt = ImmI;
                case (funct3)
                    3'b000:  instr = RVM_INSTR_LB;
                    3'b001:  instr = RVM_INSTR_LH;
                    3'b010:  instr = RVM_INSTR_LW;
                    3'b100:  instr = RVM_INSTR_LBU;
                    3'b101:  instr = RVM_INSTR_LHU;
                    default: instr = RVM_INSTR_INVALID;
                endcase
            end
            RVM_OPCODE_STORE: begin
                fmt = ImmS;
                case (funct3)
                    3'b000:  instr = RVM_INSTR_SB;
                    3'b001:  instr = RVM_INSTR_SH;
                    3'b010:  instr = RVM_INSTR_SW;
                    default: instr = RVM_INSTR_INVALID;
                endcase
            end
            RVM_OPCODE_OP_IMM: begin
                fmt = ImmI;
                case (funct3)
                    3'b000: instr = RVM_INSTR_ADDI;
                    3'b010: instr = RVM_INSTR_SLTI;
                    3'b011: instr = RVM_INSTR_SLTIU;
                    3'b100: instr = RVM_INSTR_XORI;
                    3'b110: instr = RVM_INSTR_ORI;
                    3'b111: instr = RVM_INSTR_ANDI;
                    3'b001: begin
                        fmt = ImmShamt;
                        if (funct7 == 7'h00) instr = RVM_INSTR_SLLI;
                    end
                    default: begin
                        fmt = ImmShamt;
                        if (funct7 == 7'h00)      instr = RVM_INSTR_SRLI;
                        else if (funct7 == 7'h20) instr = RVM_INSTR_SRAI;
                    end
                endcase
            end
            RVM_OPCODE_OP: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000:  instr = RVM_INSTR_ADD;
                        3'b001:  instr = RVM_INSTR_SLL;
                        3'b010:  instr = RVM_INSTR_SLT;
                        3'b011:  instr = RVM_INSTR_SLTU;
                        3'b100:  instr = RVM_INSTR_XOR;
                        3'b101:  instr = RVM_INSTR_SRL;
                        3'b110:  instr = RVM_INSTR_OR;
                        default: instr = RVM_INSTR_AND;
                    endcase
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'b000)      instr = RVM_INSTR_SUB;
                    else if (funct3 == 3'b101) instr = RVM_INSTR_SRA;
                end
            end
            RVM_OPCODE_MISC_MEM: begin
                fmt = ImmI;
                if (funct3 == 3'b000) instr = RVM_INSTR_FENCE;
            end
            RVM_OPCODE_SYSTEM: begin
                fmt = ImmI;
                // rs1, funct3 and rd must all be zero for ECALL/EBREAK
                if (ir[19:7] == 13'd0) begin
                    if (ir[31:20] == 12'd0)      instr = RVM_INSTR_ECALL;
                    else if (ir[31:20] == 12'd1) instr = RVM_INSTR_EBREAK;
                end
            end
            default: instr = RVM_INSTR_INVALID;
        endcase
    end

    assign illegal = (instr == RVM_INSTR_INVALID);
    assign imm     = illegal ? 32'd0 : imm_gen(ir, fmt);

endmodule

// File: rtl/rvm_instr_decode.sv
// Fetch-capture and decode stage: latches the instruction word when the memory read
// completes, decodes it one cycle later and holds the registered fields until the next fetch.
module rvm_instr_decode
    import rvm_instr_decode_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    input  logic        mem_error,
    output logic        d_valid,
    output logic        d_error,
    output logic [31:0] d_ir,
    output logic [4:0]  i_rs1_addr,
    output logic [4:0]  i_rs2_addr,
    output logic [4:0]  i_rd_addr,
    output logic [31:0] i_immediate,
    output logic [5:0]  i_instr
);

    state_e      state_q, state_d;
    logic        err_q;
    logic        start;
    logic        capture;
    logic [5:0]  dec_instr;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    // A fetch is only accepted between transactions; f_req in WAIT/DECODE is dropped.
    assign start   = f_req && ((state_q == StIdle) || (state_q == StHold));
    assign capture = !mem_stall && (start || (state_q == StWait));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (start) state_d = capture ? StDecode : StWait;
            end
            StWait: begin
                if (capture) state_d = StDecode;
            end
            StDecode: state_d = StHold;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_ir  <= RESET_INSTR;
            err_q <= 1'b0;
        end else if (capture) begin
            d_ir  <= mem_rdata;
            err_q <= mem_error;
        end
    end

    rvm_decode_comb u_decode_comb (
        .ir      (d_ir),
        .instr   (dec_instr),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_valid     <= 1'b0;
            d_error     <= 1'b0;
            i_rs1_addr  <= 5'd0;
            i_rs2_addr  <= 5'd0;
            i_rd_addr   <= 5'd0;
            i_immediate <= 32'd0;
            i_instr     <= 6'd0;
        end else if (start) begin
            d_valid <= 1'b0;
            d_error <= 1'b0;
        end else if (state_q == StDecode) begin
            d_valid     <= 1'b1;
            d_error     <= err_q || dec_illegal;
            i_rs1_addr  <= d_ir[19:15];
            i_rs2_addr  <= d_ir[24:20];
            i_rd_addr   <= d_ir[11:7];
            // A bus error overrides whatever the captured word happened to decode to
            i_immediate <= err_q ? 32'd0 : dec_imm;
            i_instr     <= err_q ? RVM_INSTR_INVALID : dec_instr;
        end
    end

endmodule
